// File: rtl/countdown_fsm_if.sv
// rtl/countdown_fsm_if.sv - control/status bundle for countdown_fsm
// master drives start/load/hold/stop; slave (the counter) returns count/busy/done.
interface countdown_fsm_if #(
  parameter int N = 32
);
  localparam int W = $clog2(N);

  logic         start;
  logic [W-1:0] load_val;
  logic         hold;
  logic         stop;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  modport master (
    output start, load_val, hold, stop,
    input  count, busy, done
  );

  modport slave (
    input  start, load_val, hold, stop,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_fsm.sv
// rtl/countdown_fsm.sv - loadable modulo-N down-counter with start/stop/hold and done pulse
// Define COUNTDOWN_FSM_AUTORELOAD_EN for periodic reload at terminal count instead of one-shot.
module countdown_fsm #(
  parameter int N = 32
) (
  input logic           clk,
  input logic           reset,
  countdown_fsm_if.slave bus
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] MAX_VAL = W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_count;
  logic         r_busy;
  logic         r_done;

  state_t       w_state_nxt;
  logic [W-1:0] w_count_nxt;
  logic         w_done_nxt;
  logic [W-1:0] w_load;

`ifdef COUNTDOWN_FSM_AUTORELOAD_EN
  logic [W-1:0] r_reload;
  logic [W-1:0] w_reload_nxt;
`endif

  assign w_load = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef COUNTDOWN_FSM_AUTORELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_state_nxt == S_COUNT);
      r_done  <= w_done_nxt;
`ifdef COUNTDOWN_FSM_AUTORELOAD_EN
      r_reload <= w_reload_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
`ifdef COUNTDOWN_FSM_AUTORELOAD_EN
    w_reload_nxt = r_reload;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_COUNT;
          w_count_nxt = w_load;
`ifdef COUNTDOWN_FSM_AUTORELOAD_EN
          w_reload_nxt = w_load;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COUNT: begin
        // stop beats hold beats decrement; start is ignored while counting
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (bus.hold) begin
          w_state_nxt = S_COUNT;
        end else if (r_count != '0) begin
          w_count_nxt = r_count - 1'b1;
        end else begin
          w_done_nxt = 1'b1;
`ifdef COUNTDOWN_FSM_AUTORELOAD_EN
          w_count_nxt = r_reload;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_comb begin
    bus.count = r_count;
    bus.busy  = r_busy;
    bus.done  = r_done;
  end
endmodule

// File: tb/tb_countdown_fsm.sv
// tb/tb_countdown_fsm.sv - scoreboard bench for countdown_fsm (N=32 and N=20 instances)
module tb_countdown_fsm;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  countdown_fsm_if #(.N(32)) bus32 ();
  countdown_fsm_if #(.N(20)) bus20 ();

  countdown_fsm #(.N(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  countdown_fsm #(.N(20)) dut20 (.clk(clk), .reset(reset), .bus(bus20.slave));

  typedef struct {
    logic       rst, st, hd, sp;
    logic [4:0] ld;
    logic [4:0] ec;
    logic       eb, ed;
    logic [4:0] ec20;
  } vec_t;

  typedef struct {
    logic [4:0] ec;
    logic       eb, ed;
    logic [4:0] ec20;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   stim_done = 1'b0;

  // expected values are the outputs after the edge that samples the row's inputs
  function automatic void add(input logic r, input logic s, input logic [4:0] l,
                              input logic h, input logic p, input logic [4:0] ec,
                              input logic eb, input logic ed, input logic [4:0] e20);
    vec_t v;
    v.rst = r; v.st = s; v.ld = l; v.hd = h; v.sp = p;
    v.ec = ec; v.eb = eb; v.ed = ed; v.ec20 = e20;
    vecs.push_back(v);
  endfunction

  function automatic void idl(input logic [4:0] ec, input logic eb, input logic ed);
    add(0, 0, 5'd0, 0, 0, ec, eb, ed, ec);
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst;
    bus32.start = v.st; bus32.load_val = v.ld; bus32.hold = v.hd; bus32.stop = v.sp;
    bus20.start = v.st; bus20.load_val = v.ld; bus20.hold = v.hd; bus20.stop = v.sp;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({bus32.count, bus32.busy, bus32.done} !== {e.ec, e.eb, e.ed}) begin
          n_err++;
          $display("FAIL n32 vec%0d: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                   n_vec, bus32.count, bus32.busy, bus32.done, e.ec, e.eb, e.ed);
        end
        if ({bus20.count, bus20.busy, bus20.done} !== {e.ec20, e.eb, e.ed}) begin
          n_err++;
          $display("FAIL n20 vec%0d: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                   n_vec, bus20.count, bus20.busy, bus20.done, e.ec20, e.eb, e.ed);
        end
      end
    end
  end

  initial begin
    exp_t e;
    vec_t v;
    add(1, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    idl(0, 0, 0); idl(0, 0, 0); idl(0, 0, 0);
`ifdef COUNTDOWN_FSM_AUTORELOAD_EN
    add(0, 1, 5'd3, 0, 0, 3, 1, 0, 3);
    for (int k = 0; k < 3; k++) begin
      idl(2, 1, 0); idl(1, 1, 0); idl(0, 1, 0); idl(3, 1, 1);
    end
    add(0, 0, 5'd0, 0, 1, 3, 0, 0, 3);
    idl(3, 0, 0); idl(3, 0, 0); idl(3, 0, 0);
`else
    // one-shot load 5: done on the 7th edge after start is driven
    add(0, 1, 5'd5, 0, 0, 5, 1, 0, 5);
    idl(4, 1, 0); idl(3, 1, 0); idl(2, 1, 0); idl(1, 1, 0); idl(0, 1, 0);
    idl(0, 0, 1); idl(0, 0, 0); idl(0, 0, 0);
    // hold three cycles at count 2
    add(0, 1, 5'd4, 0, 0, 4, 1, 0, 4);
    idl(3, 1, 0); idl(2, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 5'd0, 1, 0, 2, 1, 0, 2);
    idl(1, 1, 0); idl(0, 1, 0); idl(0, 0, 1); idl(0, 0, 0);
    // stop at count 3
    add(0, 1, 5'd7, 0, 0, 7, 1, 0, 7);
    idl(6, 1, 0); idl(5, 1, 0); idl(4, 1, 0); idl(3, 1, 0);
    add(0, 0, 5'd0, 0, 1, 3, 0, 0, 3);
    idl(3, 0, 0);
    // stop and hold together
    add(0, 1, 5'd2, 0, 0, 2, 1, 0, 2);
    add(0, 0, 5'd0, 1, 1, 2, 0, 0, 2);
    idl(2, 0, 0);
    // load 0
    add(0, 1, 5'd0, 0, 0, 0, 1, 0, 0);
    idl(0, 0, 1); idl(0, 0, 0);
    // start in COUNT ignored, start in DONE reloads with no gap
    add(0, 1, 5'd3, 0, 0, 3, 1, 0, 3);
    add(0, 1, 5'd9, 0, 0, 2, 1, 0, 2);
    idl(1, 1, 0); idl(0, 1, 0); idl(0, 0, 1);
    add(0, 1, 5'd2, 0, 0, 2, 1, 0, 2);
    idl(1, 1, 0); idl(0, 1, 0); idl(0, 0, 1); idl(0, 0, 0);
    // clamp: N=20 loads 19
    add(0, 1, 5'd31, 0, 0, 31, 1, 0, 19);
    add(0, 0, 5'd0, 0, 1, 31, 0, 0, 19);
    add(0, 0, 5'd0, 0, 0, 31, 0, 0, 19);
    // reset at count 10
    add(0, 1, 5'd12, 0, 0, 12, 1, 0, 12);
    idl(11, 1, 0); idl(10, 1, 0);
    add(1, 0, 5'd0, 0, 0, 0, 0, 0, 0);
    idl(0, 0, 0); idl(0, 0, 0);
`endif

    drive(vecs[0]);
    foreach (vecs[i]) begin
      @(negedge clk);
      v = vecs[i];
      drive(v);
      e.ec = v.ec; e.eb = v.eb; e.ed = v.ed; e.ec20 = v.ec20;
      sb.push_back(e);
    end
    @(negedge clk);
    v = '{rst: 1'b0, st: 1'b0, hd: 1'b0, sp: 1'b0, ld: 5'd0, ec: 5'd0, eb: 1'b0, ed: 1'b0, ec20: 5'd0};
    drive(v);
    stim_done = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
